// File: rtl/serial_sub_ctrl_pkg.sv
// ============================================================================
// Module      : serial_sub_ctrl_pkg
// Description : Shared FSM encodings and default operand width for serial_sub_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_sub_ctrl_fullsub.sv
// ============================================================================
// Module      : serial_sub_ctrl_fullsub
// Description : One-bit full subtractor cell, d = a - b - bi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl_fullsub (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial, LSB-first subtractor computing a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               brw_q;
    logic               busy_q;
    logic               done_q;
    logic               bout_q;
    logic               ovf_q;

    logic               bit_d;
    logic               brw_d;
    logic [WIDTH-1:0]   res_d;

    serial_sub_ctrl_fullsub u_fullsub (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .bi_i (brw_q),
        .d_o  (bit_d),
        .bo_o (brw_d)
    );

    // Result enters at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    brw_q <= brw_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // brw_q still holds the borrow into the MSB here.
                        bout_q  <= brw_d;
                        ovf_q   <= brw_q ^ brw_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;
    import serial_sub_ctrl_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             bin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"},  32'(ovf),  32'(eo));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ed, input logic eb,
                          input logic eo, input bit disturb);
        int k;
        int extra;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nodone"}, 32'(done), 32'd0);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            if (disturb && k == 3) begin
                start = 1'b1; a = ~ia; b = ~ib; bin = ~ibin;
            end else if (disturb && k == 4) begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(WIDTH));
        check_result(tag, ed, eb, eo);
        tick();
        chk({tag, "_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(diff), 32'(ed));
        if (disturb) begin
            extra = 0;
            repeat (14) begin
                tick();
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            chk({tag, "_no_restart"}, 32'(extra), 32'd0);
            chk({tag, "_hold_late"}, 32'(diff), 32'(ed));
        end
    endtask

    initial begin
        int k;
        int t0;
        int t1;
        int cnt;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(busy), 32'd0);

        run_op("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("sub_80_1",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("sub_0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("disturb",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation; leave bout/ovf set beforehand
        run_op("pre_rst",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        chk("arst_ovf",  32'(ovf),  32'd0);
        start = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        start = 1'b0;
        cnt = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);
        run_op("after_rst", 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);

        // Back-to-back with start held high
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        wait_done(k);
        chk("b2b0_latency", 32'(k), 32'(WIDTH));
        t0 = cyc;
        check_result("b2b0", 8'h02, 1'b0, 1'b0);
        a = 8'h10; b = 8'h20; bin = 1'b1;
        tick();
        chk("b2b0_pulse_end", 32'(done), 32'd0);
        wait_done(k);
        t1 = cyc;
        chk("b2b1_spacing", 32'(t1 - t0), 32'(WIDTH + 2));
        check_result("b2b1", 8'hEF, 1'b1, 1'b0);
        a = 8'h7F; b = 8'hFF; bin = 1'b0;
        t0 = t1;
        tick();
        wait_done(k);
        t1 = cyc;
        start = 1'b0;
        chk("b2b2_spacing", 32'(t1 - t0), 32'(WIDTH + 2));
        check_result("b2b2", 8'h80, 1'b1, 1'b1);
        repeat (3) tick();
        chk("b2b_end_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL take parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on the edge that accepts start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on the same edge.
REQ-007 SHALL have port bin  input  1  borrow-in, captured on the same edge.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking diff/bout/ovf valid.
REQ-010 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow out of the MSB.
REQ-012 SHALL have port ovf  output  1  two's-complement overflow flag.

Function
REQ-013 SHALL compute the result bit-serially, LSB first, through one full-subtractor cell, one bit per clock.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE: IDLE->SHIFT when start=1; SHIFT->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-015 SHALL, on accepting start, load a and b into shift registers, load the borrow flop with bin, and clear the bit counter (width clog2(WIDTH)+1).
REQ-016 SHALL, on each SHIFT edge, feed shift-register LSBs and the borrow flop to the cell, shift the cell's diff bit into the result register from the MSB end, and update the borrow flop with the cell's borrow.
REQ-017 SHALL assert done for exactly one cycle (the DONE state), beginning WIDTH rising edges after the edge that accepted start.
REQ-018 SHALL hold busy high in SHIFT only; busy and done SHALL never be high together.
REQ-019 SHALL set bout to the final borrow flop value and ovf to (borrow into MSB) XOR (borrow out of MSB).
REQ-020 SHALL hold diff, bout and ovf stable from the done pulse until the next accepted start.
REQ-021 SHALL ignore start while in SHIFT or DONE; a and b changing during SHIFT SHALL NOT affect the result.
REQ-022 SHALL accept start in the IDLE cycle that directly follows DONE, giving back-to-back throughput of one operation per WIDTH+2 cycles.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, clear counter, shift registers and borrow flop.
REQ-024 SHALL abort any in-progress operation on reset assertion with no done pulse; after release the block waits in IDLE for a fresh start.
REQ-025 SHALL ignore start on the first rising edge following reset deassertion only if rst_n is still low at that edge; otherwise normal IDLE sampling applies.

Structure
REQ-026 SHALL place FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH in a shared package/include for reuse by the testbench.
REQ-027 SHALL instantiate the existing fullsub cell as the single sub-module for the per-bit arithmetic; no other arithmetic is permitted on the operand path.

Verification
REQ-028 SHALL cover WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, done exactly 8 edges after start edge.
REQ-029 SHALL cover a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
REQ-030 SHALL cover a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; and a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-031 SHALL cover start pulsed and a/b changed mid-SHIFT -> no restart, original result delivered, single done pulse.
REQ-032 SHALL cover rst_n low at bit-cycle 4 of an operation -> all outputs 0 immediately, no done; new start after release -> correct result.
REQ-033 SHALL cover back-to-back operations with start held high -> results for each, done pulses spaced exactly WIDTH+2 cycles apart.
